// File: rtl/ring_nic_buffered.sv
// Network interface between a processor data port and a ring router PE port.
// Two small FIFOs (ingress/egress) plus status registers behind a 4-word register map.
module ring_nic_buffered #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_polarity,
  input  logic          i_nic_en,
  input  logic          i_nic_wren,
  input  logic [1:0]    i_addr,
  input  logic [DW-1:0] i_nic_din,
  output logic [DW-1:0] o_nic_dout,
  output logic          o_net_si,
  input  logic          i_net_ri,
  output logic [DW-1:0] o_net_do,
  input  logic          i_net_so,
  output logic          o_net_ro,
  input  logic [DW-1:0] i_net_di
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

  logic [DW-1:0] r_in_mem  [DEPTH];
  logic [DW-1:0] r_out_mem [DEPTH];
  logic [AW-1:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic          r_ovf;

  logic          w_rd, w_wr;
  logic          w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic          w_ovf_set, w_st_rd;
  logic          w_in_empty, w_out_empty, w_out_full;
  logic [DW-1:0] w_in_head, w_out_head, w_rd_data;

  assign w_in_head   = r_in_mem[r_in_rp];
  assign w_out_head  = r_out_mem[r_out_rp];
  assign w_in_empty  = (r_in_cnt == '0);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_full  = (r_out_cnt == L_FULL);

  assign w_rd = i_rst_n & i_nic_en & ~i_nic_wren;
  assign w_wr = i_rst_n & i_nic_en & i_nic_wren;

  // The VC bit is the packet MSB (bit 0 in the processor's MSB-first numbering).
  assign o_net_ro = i_rst_n & (r_in_cnt != L_FULL);
  assign o_net_si = i_rst_n & ~w_out_empty & (w_out_head[DW-1] != i_polarity);
  assign o_net_do = w_out_empty ? '0 : w_out_head;

  // Fullness is judged on the pre-edge count: no same-cycle bypass on either FIFO.
  assign w_in_push  = i_net_so & o_net_ro;
  assign w_in_pop   = w_rd & (i_addr == 2'b00) & ~w_in_empty;
  assign w_out_push = w_wr & (i_addr == 2'b10) & ~w_out_full;
  assign w_out_pop  = o_net_si & i_net_ri;
  assign w_ovf_set  = w_wr & (i_addr == 2'b10) & w_out_full;
  assign w_st_rd    = w_rd & (i_addr == 2'b11);

  always_comb begin
    w_rd_data = '0;
    case (i_addr)
      2'b00: if (!w_in_empty) w_rd_data = w_in_head;
      2'b01: begin
        w_rd_data[DW-1]      = ~w_in_empty;
        w_rd_data[DW-2 -: CW] = r_in_cnt;
      end
      2'b11: begin
        w_rd_data[DW-1]   = w_out_full;
        w_rd_data[DW-2]   = r_ovf;
        w_rd_data[CW-1:0] = r_out_cnt;
      end
      default: w_rd_data = '0;
    endcase
  end

  assign o_nic_dout = w_rd ? w_rd_data : '0;

  always_ff @(posedge i_clk) begin
    if (w_in_push)  r_in_mem[r_in_wp]   <= i_net_di;
    if (w_out_push) r_out_mem[r_out_wp] <= i_nic_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_in_push)  r_in_wp  <= r_in_wp + AW'(1);
      if (w_in_pop)   r_in_rp  <= r_in_rp + AW'(1);
      if (w_out_push) r_out_wp <= r_out_wp + AW'(1);
      if (w_out_pop)  r_out_rp <= r_out_rp + AW'(1);
      r_in_cnt  <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
      r_out_cnt <= r_out_cnt + CW'(w_out_push) - CW'(w_out_pop);
      // A new overflow outranks the clear from a status read in the same cycle.
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (w_st_rd) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_nic_buffered.sv
// Self-checking bench for ring_nic_buffered: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ring_nic_buffered;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          polarity, nic_en, nic_wren, net_ri, net_so;
  logic [1:0]    addr;
  logic [DW-1:0] nic_din, net_di;
  logic [DW-1:0] nic_dout, net_do;
  logic          net_si, net_ro;

  always #5 clk = ~clk;

  ring_nic_buffered #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_polarity (polarity),
    .i_nic_en   (nic_en),
    .i_nic_wren (nic_wren),
    .i_addr     (addr),
    .i_nic_din  (nic_din),
    .o_nic_dout (nic_dout),
    .o_net_si   (net_si),
    .i_net_ri   (net_ri),
    .o_net_do   (net_do),
    .i_net_so   (net_so),
    .o_net_ro   (net_ro),
    .i_net_di   (net_di)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q_in[$];
  logic [DW-1:0] q_out[$];
  bit            m_ovf = 1'b0;

  logic [DW-1:0] obs_dout, obs_do;
  logic          obs_si, obs_ro;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, commit model at posedge.
  task automatic cycle(input bit en, input bit wren, input bit [1:0] a, input bit [DW-1:0] din,
                       input bit pol, input bit ri, input bit so, input bit [DW-1:0] di);
    logic [DW-1:0] e_dout, e_do;
    bit e_si, e_ro, rd, wr;
    int nin, nout;
    @(negedge clk);
    nic_en = en; nic_wren = wren; addr = a; nic_din = din;
    polarity = pol; net_ri = ri; net_so = so; net_di = di;
    if (!rst_n) begin
      q_in.delete();
      q_out.delete();
      m_ovf = 1'b0;
    end
    #1;
    nin  = q_in.size();
    nout = q_out.size();
    rd   = rst_n && en && !wren;
    wr   = rst_n && en && wren;
    e_ro = rst_n && (nin != DEPTH);
    e_si = rst_n && (nout != 0) && (q_out[0][DW-1] != pol);
    e_do = (nout != 0) ? q_out[0] : '0;
    e_dout = '0;
    if (rd) begin
      case (a)
        2'd0: if (nin != 0) e_dout = q_in[0];
        2'd1: e_dout = ((nin != 0) ? 64'h8000_0000_0000_0000 : 64'h0) | (64'(nin) << 60);
        2'd3: e_dout = ((nout == DEPTH) ? 64'h8000_0000_0000_0000 : 64'h0) |
                       (m_ovf ? 64'h4000_0000_0000_0000 : 64'h0) | 64'(nout);
        default: e_dout = '0;
      endcase
    end
    obs_dout = nic_dout; obs_do = net_do; obs_si = net_si; obs_ro = net_ro;
    check("nic_dout", obs_dout, e_dout);
    check("net_do", obs_do, e_do);
    check("net_si", 64'(obs_si), 64'(e_si));
    check("net_ro", 64'(obs_ro), 64'(e_ro));
    @(posedge clk);
    if (rst_n) begin
      if (rd && a == 2'd0 && nin != 0) begin
        $display("ingress read %h", q_in[0]);
        void'(q_in.pop_front());
      end
      if (so && e_ro) q_in.push_back(di);
      if (e_si && ri) begin
        $display("egress send  %h", q_out[0]);
        void'(q_out.pop_front());
      end
      if (wr && a == 2'd2 && nout != DEPTH) q_out.push_back(din);
      if (wr && a == 2'd2 && nout == DEPTH) m_ovf = 1'b1;
      else if (rd && a == 2'd3) m_ovf = 1'b0;
    end
  endtask

  task automatic set_rst(input bit v);
    #2 rst_n = v;
  endtask

  initial begin
    rst_n = 1'b1; polarity = 1'b0; nic_en = 1'b0; nic_wren = 1'b0; addr = 2'd0;
    nic_din = '0; net_ri = 1'b0; net_so = 1'b0; net_di = '0;
    #2 rst_n = 1'b0;

    // Reset holds everything idle even with ingress offered.
    cycle(1, 0, 2'd1, 0, 0, 1, 1, 64'h77);
    check("rst_ro", 64'(obs_ro), 64'h0);
    check("rst_st01", obs_dout, 64'h0);
    cycle(1, 0, 2'd3, 0, 1, 1, 1, 64'h78);
    check("rst_st11", obs_dout, 64'h0);
    check("rst_si", 64'(obs_si), 64'h0);
    set_rst(1'b1);
    cycle(0, 0, 2'd0, 0, 0, 0, 0, 0);
    check("rel_ro", 64'(obs_ro), 64'h1);

    // Egress polarity gating.
    cycle(1, 1, 2'd2, 64'h0000_0000_0000_00A5, 0, 1, 0, 0);
    cycle(0, 0, 2'd0, 0, 0, 1, 0, 0);
    check("pol0_si", 64'(obs_si), 64'h0);
    cycle(0, 0, 2'd0, 0, 1, 1, 0, 0);
    check("pol1_si", 64'(obs_si), 64'h1);
    check("pol1_do", obs_do, 64'hA5);
    cycle(1, 0, 2'd3, 0, 1, 1, 0, 0);
    check("eg_empty", obs_dout, 64'h0);

    // Ingress fill and in-order drain.
    for (int i = 1; i <= 4; i++) cycle(0, 0, 2'd0, 0, 0, 0, 1, 64'(i));
    cycle(0, 0, 2'd0, 0, 0, 0, 1, 64'h5);
    check("full_ro", 64'(obs_ro), 64'h0);
    cycle(1, 0, 2'd1, 0, 0, 0, 0, 0);
    check("st01_full", obs_dout, 64'hC000_0000_0000_0000);
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 2'd0, 0, 0, 0, 0, 0);
      check("in_order", obs_dout, 64'(i));
    end
    cycle(1, 0, 2'd0, 0, 0, 0, 0, 0);
    check("in_empty_rd", obs_dout, 64'h0);

    // Egress overflow and sticky flag clear.
    for (int i = 1; i <= 5; i++) cycle(1, 1, 2'd2, 64'h100 + 64'(i), 1, 0, 0, 0);
    cycle(1, 0, 2'd3, 0, 1, 0, 0, 0);
    check("ovf_set", obs_dout, 64'hC000_0000_0000_0004);
    cycle(1, 0, 2'd3, 0, 1, 0, 0, 0);
    check("ovf_clr", obs_dout, 64'h8000_0000_0000_0004);
    for (int i = 0; i < 6; i++) cycle(0, 0, 2'd0, 0, 1, 1, 0, 0);

    // Simultaneous push and pop leave counts unchanged.
    cycle(0, 0, 2'd0, 0, 0, 0, 1, 64'h11);
    cycle(0, 0, 2'd0, 0, 0, 0, 1, 64'h22);
    cycle(1, 0, 2'd0, 0, 0, 0, 1, 64'h33);
    check("sim_in_pop", obs_dout, 64'h11);
    cycle(1, 0, 2'd1, 0, 0, 0, 0, 0);
    check("sim_in_cnt", obs_dout, 64'hA000_0000_0000_0000);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'd0, 0, 0, 0, 0, 0);
    cycle(1, 1, 2'd2, 64'h10, 1, 0, 0, 0);
    cycle(1, 1, 2'd2, 64'h20, 1, 0, 0, 0);
    cycle(1, 1, 2'd2, 64'h30, 1, 1, 0, 0);
    check("sim_eg_do", obs_do, 64'h10);
    cycle(1, 0, 2'd3, 0, 0, 0, 0, 0);
    check("sim_out_cnt", obs_dout, 64'h2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'd0, 0, 1, 1, 0, 0);

    // Random traffic with a mid-run reset pulse.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) set_rst(1'b0);
      if (i == 302) set_rst(1'b1);
      cycle(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), {$urandom, $urandom},
            $urandom % 2, ($urandom % 4) != 0, $urandom % 2, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
